// File: rtl/nco_pkg.sv
// -----------------------------------------------------------------------------
// nco_pkg
// Constants and types shared by the LUT-based NCO and its receive-side
// frequency meter.
//   LUT_WIDTH  : signed sample width produced by the NCO lookup table
//   ACC_SIZE   : signed step (tuning) word width
//   PHASE_BITS : phase units per full cycle = 2**PHASE_BITS
//   meter_state_e : frequency meter FSM states
//   polarity_e    : hysteresis polarity tracker states
//   meter_dbg_t   : debug view of the meter's internal state
// -----------------------------------------------------------------------------
package nco_pkg;

   localparam int LUT_WIDTH  = 16;
   localparam int ACC_SIZE   = 9;
   localparam int PHASE_BITS = ACC_SIZE + 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_DONE    = 2'd2
   } meter_state_e;

   typedef enum logic [1:0] {
      POL_UNKNOWN = 2'd0,
      POL_LOW     = 2'd1,
      POL_HIGH    = 2'd2
   } polarity_e;

   typedef struct packed {
      meter_state_e state;
      polarity_e    polarity;
   } meter_dbg_t;

endpackage

// File: rtl/nco_freq_meter_zero_cross.sv
// -----------------------------------------------------------------------------
// zero_cross_detector
// Hysteresis polarity tracker for a signed sinusoid. A sample >= HYST marks
// the signal HIGH, a sample <= -HYST marks it LOW, anything in between keeps
// the previous polarity. orise flags the enabled sample that moves the
// tracker from LOW to HIGH (UNKNOWN -> HIGH is not a rising event).
// Ports:
//   iclk, iresetn : clock, asynchronous active-low reset
//   ien           : sample enable; when low the tracker holds
//   in_sample     : signed input sample
//   opolarity     : current tracked polarity
//   orise         : combinational, high for the sample causing LOW -> HIGH
// -----------------------------------------------------------------------------
module zero_cross_detector #(
   parameter int LUT_WIDTH = 16,
   parameter int HYST      = 256
) (
   input  logic                        iclk,
   input  logic                        iresetn,
   input  logic                        ien,
   input  logic signed [LUT_WIDTH-1:0] in_sample,
   output nco_pkg::polarity_e          opolarity,
   output logic                        orise
);

   import nco_pkg::*;

   localparam logic signed [LUT_WIDTH-1:0] HYST_POS = LUT_WIDTH'(HYST);
   localparam logic signed [LUT_WIDTH-1:0] HYST_NEG = LUT_WIDTH'(-HYST);

   polarity_e pol_q;
   polarity_e pol_d;
   logic      above;
   logic      below;

   assign above = (in_sample >= HYST_POS);
   assign below = (in_sample <= HYST_NEG);

   always_comb begin
      pol_d = pol_q;
      if (above) begin
         pol_d = POL_HIGH;
      end else if (below) begin
         pol_d = POL_LOW;
      end
   end

   always_ff @(posedge iclk or negedge iresetn) begin
      if (!iresetn) begin
         pol_q <= POL_UNKNOWN;
      end else if (ien) begin
         pol_q <= pol_d;
      end
   end

   assign orise     = ien && (pol_q == POL_LOW) && above;
   assign opolarity = pol_q;

endmodule

// File: rtl/nco_freq_meter.sv
// -----------------------------------------------------------------------------
// nco_freq_meter
// Recovers the NCO step magnitude from a sampled sinusoid by counting
// hysteresis-qualified rising zero crossings over a gate of 2**GATE_LOG2
// enabled samples, then scaling the count into phase units per sample.
// Ports:
//   iclk, iresetn : clock, asynchronous active-low reset
//   inCS          : active-low sample enable; when high all state freezes
//   istart        : single-cycle measurement request (honoured in IDLE only)
//   icontinuous   : re-arm automatically after each result
//   in_sample     : signed input sample
//   step_est      : estimated |step|, held until the next result
//   ovalid        : one enabled-cycle pulse when step_est updates
//   obusy         : high while acquiring
//   overflow      : estimate saturated, updated with step_est
//   odbg          : FSM state and tracked polarity, for observation only
// -----------------------------------------------------------------------------
module nco_freq_meter #(
   parameter int LUT_WIDTH  = nco_pkg::LUT_WIDTH,
   parameter int ACC_SIZE   = nco_pkg::ACC_SIZE,
   parameter int PHASE_BITS = nco_pkg::PHASE_BITS,
   parameter int GATE_LOG2  = 11,
   parameter int HYST       = 256
) (
   input  logic                        iclk,
   input  logic                        iresetn,
   input  logic                        inCS,
   input  logic                        istart,
   input  logic                        icontinuous,
   input  logic signed [LUT_WIDTH-1:0] in_sample,
   output logic signed [ACC_SIZE-1:0]  step_est,
   output logic                        ovalid,
   output logic                        obusy,
   output logic                        overflow,
   output nco_pkg::meter_dbg_t         odbg
);

   import nco_pkg::*;

   localparam int SHIFT = (GATE_LOG2 <= PHASE_BITS) ? (PHASE_BITS - GATE_LOG2)
                                                    : (GATE_LOG2 - PHASE_BITS);
   // Intermediate width wide enough for either scaling direction.
   localparam int EW = ((GATE_LOG2 > PHASE_BITS) ? GATE_LOG2 : PHASE_BITS) + 1;
   // Half of one output LSB, only used when the gate is longer than a cycle.
   localparam logic [EW-1:0] RND = (GATE_LOG2 > PHASE_BITS) ?
                                   (EW'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;
   localparam logic [PHASE_BITS:0]  SAT      = (PHASE_BITS+1)'((1 << (ACC_SIZE - 1)) - 1);
   localparam logic [GATE_LOG2-1:0] LAST_CNT = '1;

   meter_state_e               state_q;
   logic [GATE_LOG2-1:0]       sample_cnt_q;
   logic [GATE_LOG2-1:0]       cross_cnt_q;
   logic signed [ACC_SIZE-1:0] step_est_q;
   logic                       ovalid_q;
   logic                       obusy_q;
   logic                       overflow_q;

   logic                       en;
   logic                       rise;
   polarity_e                  pol;
   logic [GATE_LOG2-1:0]       cross_d;
   logic [EW-1:0]              cnt_ext;
   logic [EW-1:0]              est_wide;
   logic [PHASE_BITS:0]        est;
   logic                       overflow_d;
   logic signed [ACC_SIZE-1:0] step_est_d;

   assign en = ~inCS;

   zero_cross_detector #(
      .LUT_WIDTH (LUT_WIDTH),
      .HYST      (HYST)
   ) u_zcd (
      .iclk      (iclk),
      .iresetn   (iresetn),
      .ien       (en),
      .in_sample (in_sample),
      .opolarity (pol),
      .orise     (rise)
   );

   // The final window sample's own event must be part of the result, so the
   // scaler works on the count including the current sample.
   assign cross_d = cross_cnt_q + GATE_LOG2'(rise);
   assign cnt_ext = EW'(cross_d);

   always_comb begin
      est_wide = '0;
      if (GATE_LOG2 <= PHASE_BITS) begin
         est_wide = cnt_ext << SHIFT;
      end else begin
         est_wide = (cnt_ext + RND) >> SHIFT;
      end
   end

   assign est        = est_wide[PHASE_BITS:0];
   assign overflow_d = (est > SAT);
   assign step_est_d = overflow_d ? SAT[ACC_SIZE-1:0] : est[ACC_SIZE-1:0];

   // Result is captured as the FSM enters DONE so step_est is already valid
   // during the ovalid cycle.
   always_ff @(posedge iclk or negedge iresetn) begin
      if (!iresetn) begin
         state_q      <= ST_IDLE;
         sample_cnt_q <= '0;
         cross_cnt_q  <= '0;
         step_est_q   <= '0;
         ovalid_q     <= 1'b0;
         obusy_q      <= 1'b0;
         overflow_q   <= 1'b0;
      end else if (en) begin
         case (state_q)
            ST_IDLE: begin
               if (istart) begin
                  state_q      <= ST_ACQUIRE;
                  sample_cnt_q <= '0;
                  cross_cnt_q  <= '0;
                  obusy_q      <= 1'b1;
               end
            end
            ST_ACQUIRE: begin
               sample_cnt_q <= sample_cnt_q + GATE_LOG2'(1);
               cross_cnt_q  <= cross_d;
               if (sample_cnt_q == LAST_CNT) begin
                  state_q    <= ST_DONE;
                  obusy_q    <= 1'b0;
                  ovalid_q   <= 1'b1;
                  step_est_q <= step_est_d;
                  overflow_q <= overflow_d;
               end
            end
            ST_DONE: begin
               ovalid_q <= 1'b0;
               if (icontinuous) begin
                  state_q      <= ST_ACQUIRE;
                  sample_cnt_q <= '0;
                  cross_cnt_q  <= '0;
                  obusy_q      <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               ovalid_q <= 1'b0;
               obusy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign step_est      = step_est_q;
   assign ovalid        = ovalid_q & en;
   assign obusy         = obusy_q;
   assign overflow      = overflow_q;
   assign odbg.state    = state_q;
   assign odbg.polarity = pol;

endmodule

// File: doc/nco_freq_meter.md
Name: nco_freq_meter

Overview:
- Receive-side counterpart of the LUT-based NCO: takes a sampled signed sinusoid, as produced by the NCO or received from a DAC/ADC loop.
- Recovers the NCO tuning word magnitude (step) by counting hysteresis-qualified rising zero crossings over a fixed gate window.
- Used for closed-loop self-test of the NCO and for measuring external tones in the same phase units.

Parameters:
- LUT_WIDTH, 16, sample width (signed), matches NCO output.
- ACC_SIZE, 9, step word width (signed); result saturates to 2^(ACC_SIZE-1)-1.
- PHASE_BITS, 11, phase units per full cycle = 2^PHASE_BITS (ACC_SIZE+2).
- GATE_LOG2, 11, gate window = 2^GATE_LOG2 enabled samples.
- HYST, 256, hysteresis threshold magnitude (positive).

Ports:
- iclk, input, 1, clock.
- iresetn, input, 1, asynchronous active-low reset.
- inCS, input, 1, active-low sample enable; when high, all state freezes.
- istart, input, 1, single-cycle measurement request.
- icontinuous, input, 1, re-arm automatically after each result.
- in_sample, input, LUT_WIDTH, signed input sample.
- step_est, output, ACC_SIZE, estimated |step| as a non-negative signed value; held until the next result.
- ovalid, output, 1, one-cycle pulse when step_est updates.
- obusy, output, 1, high in ACQUIRE.
- overflow, output, 1, estimate saturated; updated together with step_est.

Behaviour:
- Reset: step_est=0, ovalid=0, obusy=0, overflow=0, FSM=IDLE, polarity=UNKNOWN, counters=0.
- Polarity tracker:
  - Runs on every enabled sample (~inCS) in all FSM states, with states UNKNOWN/LOW/HIGH.
  - in_sample >= HYST sets HIGH; in_sample <= -HYST sets LOW; otherwise holds.
  - A rising event is a LOW->HIGH transition only. UNKNOWN->HIGH is not an event.
- FSM states are IDLE, ACQUIRE, DONE.
- IDLE:
  - ~inCS and istart -> ACQUIRE; clear sample_cnt (GATE_LOG2 bits) and cross_cnt (GATE_LOG2 bits).
  - istart with inCS high is ignored.
- ACQUIRE:
  - Each enabled sample increments sample_cnt, and increments cross_cnt if that sample causes a rising event.
  - The sample taken at sample_cnt = 2^GATE_LOG2-1 is the last counted (including its event); then -> DONE.
  - istart is ignored while busy.
- DONE (one enabled cycle):
  - Register the scaled result and pulse ovalid high for exactly that cycle.
  - Then -> ACQUIRE with counters cleared if icontinuous, else -> IDLE.
  - In continuous mode, the sample accepted during DONE is not counted. Windows are back-to-back, with a one-sample gap.
- Scaling, s = |PHASE_BITS-GATE_LOG2|:
  - GATE_LOG2 <= PHASE_BITS: est = cross_cnt << s.
  - Otherwise: est = (cross_cnt + 2^(s-1)) >> s, rounding half up.
  - Compute at PHASE_BITS+1 bits. If est > 2^(ACC_SIZE-1)-1, step_est = 2^(ACC_SIZE-1)-1 and overflow=1; else overflow=0.
- Latency: ovalid is high on the first enabled cycle after the final window sample is accepted.
- inCS high: FSM, counters, polarity, and ovalid all hold. The ovalid pulse is extended only if inCS rises during DONE. ovalid is gated: asserted only when ~inCS.
- Sign of step is unrecoverable from a real tone; the output is always >= 0.
- Reset mid-ACQUIRE: immediate return to reset values; the partial count is discarded.
- cross_cnt cannot wrap: max events = 2^(GATE_LOG2-1).

Decomposition:
- Shared package nco_pkg holds:
  - constants LUT_WIDTH, ACC_SIZE, PHASE_BITS, shared with the NCO;
  - the FSM state enum (IDLE/ACQUIRE/DONE);
  - the polarity enum (UNKNOWN/LOW/HIGH).
- Sub-module zero_cross_detector: polarity tracker plus rising-event output, parameterised by LUT_WIDTH and HYST.
- Gate counter, FSM and scaling stay in nco_freq_meter.

Test Plan:
- Square-wave stimulus (starts -1000, period 128 samples, continuous inCS low), istart, defaults -> after 2048 samples ovalid pulses once, step_est=16, overflow=0.
- Noise uniformly in [-100,100] -> step_est=0 (no events). Then a single sample sequence -1000,+1000 -> step_est=1.
- Alternating +1000/-1000 every sample -> cross_cnt=1024, step_est=255, overflow=1.
- Square-wave case with inCS held high for 500 cycles mid-window -> step_est=16, ovalid exactly 500 cycles later than in the first case, obusy held high throughout.
- iresetn pulsed low at sample 1000 of ACQUIRE -> all outputs 0 immediately. A new istart then yields step_est=16 after 2048 further samples.
- icontinuous=1, period-64 square wave -> ovalid every 2049 enabled cycles, step_est=32 each time (GATE_LOG2=12 variant: 64 events -> step_est=32 via round-half-up).
